// File: rtl/inst_queue_pkg.sv
// Shared types and default sizing for the fetch-to-decode instruction queue.
package inst_queue_pkg;

  localparam int INST_Q_DEPTH      = 8;
  localparam int INST_Q_ADDR_WIDTH = 32;
  localparam int INST_Q_DATA_WIDTH = 32;

  typedef struct packed {
    logic [INST_Q_ADDR_WIDTH-1:0] pc;
    logic [INST_Q_DATA_WIDTH-1:0] instr;
  } inst_q_entry_t;

  // Occupancy needs one bit more than a pointer so that DEPTH itself fits.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decoder-facing signals of the instruction queue; slave is the queue side.
interface inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int DEPTH      = INST_Q_DEPTH,
  parameter int ADDR_WIDTH = INST_Q_ADDR_WIDTH,
  parameter int DATA_WIDTH = INST_Q_DATA_WIDTH
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic                  in_valid;
  logic [ADDR_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  flush;
  logic                  out_ready;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;

  modport slave (
    input  in_valid, in_pc, in_data, flush, out_ready,
    output out_valid, out_pc, out_data, full, empty, count
  );

  modport master (
    output in_valid, in_pc, in_data, flush, out_ready,
    input  out_valid, out_pc, out_data, full, empty, count
  );

endinterface

// File: rtl/inst_queue_mem.sv
// DEPTH-entry register array: one synchronous write port, one combinational read port.
module inst_queue_mem #(
  parameter int  DEPTH   = inst_queue_pkg::INST_Q_DEPTH,
  parameter type entry_t = inst_queue_pkg::inst_q_entry_t,
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  entry_t        wdata_i,
  input  logic [PW-1:0] raddr_i,
  output entry_t        rdata_o
);

  entry_t mem_q [DEPTH];

  // NOTE: storage has no reset; validity is tracked by count, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_queue.sv
// First-word-fall-through instruction queue between fetch and decode, with flush.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH      = INST_Q_DEPTH,
  parameter int ADDR_WIDTH = INST_Q_ADDR_WIDTH,
  parameter int DATA_WIDTH = INST_Q_DATA_WIDTH
) (
  input logic        clk,
  input logic        rst_n,
  inst_queue_if.slave q
);

  localparam int             PW       = $clog2(DEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          full_w, empty_w, enq, deq;
  entry_t        wr_entry, rd_entry;

  // Status depends on count alone, so full never sees out_ready or in_*.
  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);
  assign enq     = q.in_valid & ~full_w & ~q.flush;
  assign deq     = ~empty_w & q.out_ready & ~q.flush;

  // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_entry = '{pc: q.in_pc, instr: q.in_data};

  inst_queue_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .clk     (clk),
    .we_i    (enq),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign q.out_valid = ~empty_w;
  assign q.out_pc    = empty_w ? '0 : rd_entry.pc;
  assign q.out_data  = empty_w ? '0 : rd_entry.instr;
  assign q.full      = full_w;
  assign q.empty     = empty_w;
  assign q.count     = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: vector table, directed corner sequences, random vs queue model.
module tb_inst_queue;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) iq ();

  inst_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (iq)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } m_entry_t;

  m_entry_t mq[$];

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        fl;
    logic        rdy;
    int          exp_cnt;
    logic        exp_full;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] data_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hA5A5, pc[31:16] ^ 16'h3C3C};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: a plain FIFO queue updated from the inputs seen at each rising edge.
  task automatic model_edge();
    bit e, d;
    if (iq.flush) begin
      mq.delete();
    end else begin
      e = iq.in_valid && (mq.size() < DEPTH);
      d = iq.out_ready && (mq.size() > 0);
      if (d) mq.delete(0);
      if (e) mq.push_back('{pc: iq.in_pc, data: iq.in_data});
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    check({tag, ".count"},     64'(iq.count), 64'(n));
    check({tag, ".empty"},     64'(iq.empty), 64'(n == 0));
    check({tag, ".full"},      64'(iq.full), 64'(n == DEPTH));
    check({tag, ".out_valid"}, 64'(iq.out_valid), 64'(n != 0));
    check({tag, ".out_pc"},    64'(iq.out_pc), (n != 0) ? 64'(mq[0].pc) : 64'd0);
    check({tag, ".out_data"},  64'(iq.out_data), (n != 0) ? 64'(mq[0].data) : 64'd0);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic rdy);
    iq.in_valid  = v;
    iq.in_pc     = pc;
    iq.in_data   = data_of(pc);
    iq.flush     = fl;
    iq.out_ready = rdy;
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] pc,
                      input logic fl, input logic rdy);
    drive(v, pc, fl, rdy);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  function automatic void add_vec(input logic v, input logic [31:0] pc, input logic rdy,
                                  input int cnt, input logic full, input logic [31:0] hpc);
    vt.push_back('{v: v, pc: pc, fl: 1'b0, rdy: rdy, exp_cnt: cnt, exp_full: full, exp_pc: hpc});
  endfunction

  initial begin
    // Fill, drop when full, full-with-dequeue rejection, then drain.
    for (int i = 0; i < 8; i++) add_vec(1'b1, 32'h100 + 32'(4 * i), 1'b0, i + 1, i == 7, 32'h100);
    add_vec(1'b1, 32'h120, 1'b0, 8, 1'b1, 32'h100);
    add_vec(1'b1, 32'h120, 1'b1, 7, 1'b0, 32'h104);
    add_vec(1'b1, 32'h120, 1'b1, 7, 1'b0, 32'h108);
    for (int k = 1; k <= 7; k++)
      add_vec(1'b0, 32'h0, 1'b1, 7 - k, 1'b0, (k < 7) ? 32'h108 + 32'(4 * k) : 32'h0);

    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #12;
    check("reset.count",     64'(iq.count), 64'd0);
    check("reset.empty",     64'(iq.empty), 64'd1);
    check("reset.full",      64'(iq.full), 64'd0);
    check("reset.out_valid", 64'(iq.out_valid), 64'd0);
    check("reset.out_pc",    64'(iq.out_pc), 64'd0);
    check("reset.out_data",  64'(iq.out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      step($sformatf("tbl%0d", i), vt[i].v, vt[i].pc, vt[i].fl, vt[i].rdy);
      check($sformatf("tbl%0d.cnt", i),  64'(iq.count), 64'(vt[i].exp_cnt));
      check($sformatf("tbl%0d.full", i), 64'(iq.full), 64'(vt[i].exp_full));
      check($sformatf("tbl%0d.pc", i),   64'(iq.out_pc), 64'(vt[i].exp_pc));
      check($sformatf("tbl%0d.data", i), 64'(iq.out_data),
            (vt[i].exp_cnt != 0) ? 64'(data_of(vt[i].exp_pc)) : 64'd0);
    end

    // Flush priority over a simultaneous enqueue and dequeue.
    for (int i = 0; i < 5; i++) step("fl_fill", 1'b1, 32'h180 + 32'(4 * i), 1'b0, 1'b0);
    step("fl_edge", 1'b1, 32'h200, 1'b1, 1'b1);
    check("flush.count", 64'(iq.count), 64'd0);
    check("flush.empty", 64'(iq.empty), 64'd1);
    step("fl_redirect", 1'b1, 32'h300, 1'b0, 1'b0);
    check("flush.redirect_pc", 64'(iq.out_pc), 64'h300);
    step("fl_pop", 1'b0, 32'h0, 1'b0, 1'b1);
    check("flush.no_0x200", 64'(iq.count), 64'd0);

    // Dequeue attempts on an empty queue must not move the read pointer.
    for (int i = 0; i < 4; i++) begin
      step("empty_rdy", 1'b0, 32'h0, 1'b0, 1'b1);
      check("empty_rdy.out_pc", 64'(iq.out_pc), 64'd0);
    end
    step("empty_after", 1'b1, 32'h400, 1'b0, 1'b0);
    check("empty_after.pc", 64'(iq.out_pc), 64'h400);
    step("empty_drain", 1'b0, 32'h0, 1'b0, 1'b1);

    // Continuous streaming: each pc appears one cycle after entry, pointers wrap.
    for (int i = 0; i < 20; i++) begin
      step("wrap", 1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b1);
      check($sformatf("wrap%0d.pc", i), 64'(iq.out_pc), 64'(32'h1000 + 32'(4 * i)));
      check($sformatf("wrap%0d.cnt", i), 64'(iq.count), 64'd1);
    end
    step("wrap_drain", 1'b0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle with three entries held.
    for (int i = 0; i < 3; i++) step("mr_fill", 1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    check("midrst.count",     64'(iq.count), 64'd0);
    check("midrst.empty",     64'(iq.empty), 64'd1);
    check("midrst.out_valid", 64'(iq.out_valid), 64'd0);
    check("midrst.out_pc",    64'(iq.out_pc), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 32'h600, 1'b0, 1'b0);
    check("post_rst.pc", 64'(iq.out_pc), 64'h600);

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      step("rand", $urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
